// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared widths, state encoding and output-enable mask for the 8/4 divider
package divider_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int CNT_W      = $clog2(DIVIDEND_W);

    localparam logic [7:0] UIO_OE_MASK = 8'h1F;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift in a dividend bit, subtract if it fits
module div_step
    import divider_pkg::*;
(
    input  logic [DIVISOR_W:0]   i_r,
    input  logic                 i_bit,
    input  logic [DIVISOR_W-1:0] i_d,
    output logic [DIVISOR_W:0]   o_r_next,
    output logic                 o_q_bit
);

    logic [DIVISOR_W:0] w_t;
    logic [DIVISOR_W:0] w_d_ext;
    logic               w_fits;

    // R is always below D, so its top bit is zero and dropping it loses nothing
    assign w_t      = {i_r[DIVISOR_W-1:0], i_bit};
    assign w_d_ext  = {1'b0, i_d};
    assign w_fits   = (w_t >= w_d_ext);

    assign o_q_bit  = w_fits;
    assign o_r_next = w_fits ? (w_t - w_d_ext) : w_t;

endmodule

// File: rtl/tt_um_sequential_divider_8by4.sv
// rtl/tt_um_sequential_divider_8by4.sv - sequential restoring divider, 8-bit dividend by 4-bit divisor
module tt_um_sequential_divider_8by4
    import divider_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    input  logic       in_valid,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic       out_done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

    state_t                r_state;
    state_t                w_state_next;

    logic [DIVIDEND_W-1:0] r_q;
    logic [DIVISOR_W:0]    r_r;
    logic [DIVISOR_W-1:0]  r_d;
    logic [CNT_W-1:0]      r_cnt;

    logic [DIVIDEND_W-1:0] r_quot;
    logic [DIVISOR_W-1:0]  r_rem;
    logic                  r_dbz;

    logic                  w_load;
    logic                  w_step;
    logic                  w_finish;
    logic                  w_zero;

    logic [DIVISOR_W:0]    w_r_next;
    logic                  w_q_bit;
    logic [DIVIDEND_W-1:0] w_q_next;

    div_step u_step (
        .i_r      (r_r),
        .i_bit    (r_q[DIVIDEND_W-1]),
        .i_d      (r_d),
        .o_r_next (w_r_next),
        .o_q_bit  (w_q_bit)
    );

    assign w_q_next = {r_q[DIVIDEND_W-2:0], w_q_bit};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The zero-divisor check spends the first BUSY cycle so both paths share the load timing
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        w_zero       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_d == '0) begin
                    w_zero       = 1'b1;
                    w_state_next = S_DONE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        w_finish     = 1'b1;
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q   <= '0;
            r_r   <= '0;
            r_d   <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_q   <= ui_in[DIVIDEND_W-1:0];
            r_d   <= uio_in[DIVISOR_W-1:0];
            r_r   <= '0;
            r_cnt <= '0;
        end else if (w_step) begin
            r_q   <= w_q_next;
            r_r   <= w_r_next;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Visible results change only on entry to DONE; the working Q/R never reach the pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else if (w_finish) begin
            r_quot <= w_q_next;
            r_rem  <= w_r_next[DIVISOR_W-1:0];
            r_dbz  <= 1'b0;
        end else if (w_zero) begin
            r_quot <= '1;
            r_rem  <= '0;
            r_dbz  <= 1'b1;
        end
    end

    assign uo_out   = r_quot;
    assign uio_out  = {3'b000, r_dbz, r_rem};
    assign uio_oe   = UIO_OE_MASK;
    assign out_done = (r_state == S_DONE);

endmodule

// File: tb/tb_tt_um_sequential_divider_8by4.sv
// tb/tb_tt_um_sequential_divider_8by4.sv - directed self-checking bench for the 8/4 sequential divider
module tb_tt_um_sequential_divider_8by4;

    logic       clk;
    logic       reset_n;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic       in_valid;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       out_done;

    int checks;
    int errors;

    tt_um_sequential_divider_8by4 dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ui_in    (ui_in),
        .uio_in   (uio_in),
        .in_valid (in_valid),
        .uo_out   (uo_out),
        .uio_out  (uio_out),
        .uio_oe   (uio_oe),
        .out_done (out_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           output int lat, output logic [7:0] q,
                           output logic [3:0] r, output logic z);
        int cyc;
        lat = -1;
        q = 8'hxx;
        r = 4'hx;
        z = 1'bx;
        ui_in = a;
        uio_in = b;
        in_valid = 1'b1;
        for (cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) in_valid = 1'b0;
            if (out_done) begin
                lat = cyc;
                q = uo_out;
                r = uio_out[3:0];
                z = uio_out[4];
                break;
            end
        end
        @(negedge clk);
        checks++;
        if (out_done !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle %0d/%0d: out_done=%b required 0", a, b, out_done);
        end
    endtask

    task automatic check_res(input string name, input int lat, input logic [7:0] q,
                             input logic [3:0] r, input logic z, input int elat,
                             input logic [7:0] eq, input logic [3:0] er, input logic ez);
        checks++;
        if (lat !== elat) begin
            errors++;
            $display("FAIL %s_latency: got %0d required %0d", name, lat, elat);
        end
        checks++;
        if ({q, r, z} !== {eq, er, ez}) begin
            errors++;
            $display("FAIL %s_result: got q=%0d r=%0d z=%b required q=%0d r=%0d z=%b",
                     name, q, r, z, eq, er, ez);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_valid = 1'b0;
        ui_in = 8'h00;
        uio_in = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({uo_out, uio_out, out_done} !== 17'h0) begin
            errors++;
            $display("FAIL reset_outputs: uo=%h uio=%h done=%b required 0", uo_out, uio_out, out_done);
        end
        checks++;
        if (uio_oe !== 8'h1F) begin
            errors++;
            $display("FAIL reset_uio_oe: got %h required 1f", uio_oe);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat; logic [7:0] q; logic [3:0] r; logic z;
        run_div(8'd200, 8'd7, lat, q, r, z);
        check_res("d200_7", lat, q, r, z, 9, 8'd28, 4'd4, 1'b0);
        run_div(8'd255, 8'd1, lat, q, r, z);
        check_res("d255_1", lat, q, r, z, 9, 8'd255, 4'd0, 1'b0);
        run_div(8'd13, 8'd15, lat, q, r, z);
        check_res("d13_15", lat, q, r, z, 9, 8'd0, 4'd13, 1'b0);
        run_div(8'd0, 8'd9, lat, q, r, z);
        check_res("d0_9", lat, q, r, z, 9, 8'd0, 4'd0, 1'b0);
        run_div(8'd77, 8'hF5, lat, q, r, z);
        check_res("d77_5_upper_ignored", lat, q, r, z, 9, 8'd15, 4'd2, 1'b0);
    endtask

    task automatic test_div_zero();
        int lat; logic [7:0] q; logic [3:0] r; logic z;
        run_div(8'd42, 8'd0, lat, q, r, z);
        check_res("d42_0", lat, q, r, z, 2, 8'hFF, 4'd0, 1'b1);
        run_div(8'd42, 8'd6, lat, q, r, z);
        check_res("d42_6_after_zero", lat, q, r, z, 9, 8'd7, 4'd0, 1'b0);
    endtask

    task automatic test_ignore_busy();
        int pulses = 0;
        int first = -1;
        logic [7:0] q = 8'h00;
        logic [3:0] r = 4'h0;
        ui_in = 8'd200;
        uio_in = 8'd7;
        in_valid = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc == 1) in_valid = 1'b0;
            if (cyc == 4) begin
                ui_in = 8'd99;
                uio_in = 8'd3;
                in_valid = 1'b1;
            end
            if (cyc == 5) in_valid = 1'b0;
            if (out_done) begin
                pulses++;
                if (first < 0) begin
                    first = cyc;
                    q = uo_out;
                    r = uio_out[3:0];
                end
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL ignore_busy_pulses: got %0d required 1", pulses);
        end
        check_res("ignore_busy", first, q, r, 1'b0, 9, 8'd28, 4'd4, 1'b0);
    endtask

    task automatic test_async_reset();
        int lat; logic [7:0] q; logic [3:0] r; logic z;
        ui_in = 8'd200;
        uio_in = 8'd7;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({uo_out, uio_out, out_done} !== 17'h0) begin
            errors++;
            $display("FAIL async_reset_outputs: uo=%h uio=%h done=%b required 0", uo_out, uio_out, out_done);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_idle: out_done=%b required 0", out_done);
        end
        run_div(8'd100, 8'd9, lat, q, r, z);
        check_res("d100_9_after_reset", lat, q, r, z, 9, 8'd11, 4'd1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int pulse_cyc[$];
        logic [7:0] qs[$];
        ui_in = 8'd21;
        uio_in = 8'd4;
        in_valid = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (out_done) begin
                pulse_cyc.push_back(cyc);
                qs.push_back(uo_out);
            end
        end
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (pulse_cyc.size() !== 3) begin
            errors++;
            $display("FAIL b2b_pulse_count: got %0d required 3", pulse_cyc.size());
        end else begin
            checks++;
            if (pulse_cyc[0] !== 9 || pulse_cyc[1] !== 19 || pulse_cyc[2] !== 29) begin
                errors++;
                $display("FAIL b2b_timing: got %0d,%0d,%0d required 9,19,29",
                         pulse_cyc[0], pulse_cyc[1], pulse_cyc[2]);
            end
            checks++;
            if (qs[2] !== 8'd5 || uio_out !== 8'h01) begin
                errors++;
                $display("FAIL b2b_result: got q=%0d uio=%h required q=5 uio=01", qs[2], uio_out);
            end
        end
    endtask

    task automatic test_sweep();
        int lat; logic [7:0] q; logic [3:0] r; logic z;
        int bad = 0;
        for (int b = 1; b < 16; b++) begin
            for (int a = 0; a < 256; a++) begin
                run_div(8'(a), 8'(b), lat, q, r, z);
                checks++;
                if (lat !== 9 || z !== 1'b0 || (int'(q) * b + int'(r)) !== a || int'(r) >= b) begin
                    errors++;
                    if (bad < 10)
                        $display("FAIL sweep %0d/%0d: got q=%0d r=%0d z=%b lat=%0d required q=%0d r=%0d z=0 lat=9",
                                 a, b, q, r, z, lat, a / b, a % b);
                    bad++;
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_div_zero();
        test_ignore_busy();
        test_async_reset();
        test_back_to_back();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
